// File: rtl/sram_wide_ctrl_pkg.sv
// Shared state encoding, bus width and default parameters for the wide-host SRAM controller.
package sram_pkg;

  localparam int SRAM_BUS_W      = 16;
  localparam int DEF_DATA_W      = 32;
  localparam int DEF_ADDR_W      = 18;
  localparam int DEF_WAIT_CYCLES = 4;
  localparam int DEF_BASE_ADDR   = 1024;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  function automatic int calc_beats(input int data_w);
    return data_w / SRAM_BUS_W;
  endfunction

endpackage

// File: rtl/sram_wide_ctrl_beat_counter.sv
// Nested cycle-within-beat / beat-within-transaction counters with terminal count.
// Counts only while en is high; both counters wrap to 0 on the terminal cycle.
module sram_beat_counter #(
  parameter int WAIT_CYCLES = 4,
  parameter int BEATS       = 2,
  localparam int CYC_W      = $clog2(WAIT_CYCLES),
  localparam int BEAT_W     = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  output logic [CYC_W-1:0]  cyc,
  output logic [BEAT_W-1:0] beat,
  output logic              last_cyc,
  output logic              tc
);

  assign last_cyc = (cyc == CYC_W'(WAIT_CYCLES - 1));
  assign tc       = en && last_cyc && (beat == BEAT_W'(BEATS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc  <= '0;
      beat <= '0;
    end else if (tc) begin
      cyc  <= '0;
      beat <= '0;
    end else if (en) begin
      if (last_cyc) begin
        cyc  <= '0;
        beat <= beat + BEAT_W'(1);
      end else begin
        cyc <= cyc + CYC_W'(1);
      end
    end
  end

endmodule

// File: rtl/sram_wide_ctrl.sv
// Splits one DATA_W host access into DATA_W/16 SRAM beats of WAIT_CYCLES clocks each.
// ready rises BEATS*WAIT_CYCLES+1 clocks after the request; the host holds its request until then.
module sram_wide_ctrl
  import sram_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES,
  parameter int BASE_ADDR   = DEF_BASE_ADDR
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [31:0]           address,
  input  logic [DATA_W-1:0]     writedata,
  input  logic [DATA_W/8-1:0]   byte_en,
  output logic [DATA_W-1:0]     read_data,
  output logic                  ready,
  inout  wire  [SRAM_BUS_W-1:0] SRAM_DQ,
  output logic [ADDR_W-1:0]     SRAM_ADDR,
  output logic                  SRAM_WE_N,
  output logic                  SRAM_UB_N,
  output logic                  SRAM_LB_N,
  output logic                  SRAM_CE_N,
  output logic                  SRAM_OE_N
);

  localparam int BEATS      = calc_beats(DATA_W);
  localparam int CYC_W      = $clog2(WAIT_CYCLES);
  localparam int BEAT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int WORD_SHIFT = $clog2(DATA_W / 8);

  state_t                state, state_nxt;
  logic                  is_wr_q;
  logic [31:0]           half_base_q;
  logic [DATA_W-1:0]     wdata_q;
  logic [DATA_W/8-1:0]   be_q;
  logic [CYC_W-1:0]      cyc;
  logic [BEAT_W-1:0]     beat;
  logic                  last_cyc;
  logic                  tc;
  logic                  req;
  logic                  in_access;
  logic                  dq_oe;
  logic [SRAM_BUS_W-1:0] wr_slice;
  logic [1:0]            be_slice;

  assign req       = wr_en | rd_en;
  assign in_access = (state == ST_ACCESS);
  assign wr_slice  = wdata_q[SRAM_BUS_W*int'(beat) +: SRAM_BUS_W];
  assign be_slice  = be_q[2*int'(beat) +: 2];
  assign SRAM_DQ   = dq_oe ? wr_slice : {SRAM_BUS_W{1'bz}};

  sram_beat_counter #(
    .WAIT_CYCLES (WAIT_CYCLES),
    .BEATS       (BEATS)
  ) u_beat_counter (
    .clk      (clk),
    .rst      (rst),
    .en       (in_access),
    .cyc      (cyc),
    .beat     (beat),
    .last_cyc (last_cyc),
    .tc       (tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Write wins when both requests are high; all request fields are frozen for the whole access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      is_wr_q     <= 1'b0;
      half_base_q <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
    end else if (state == ST_IDLE && req) begin
      is_wr_q     <= wr_en;
      half_base_q <= ((address - 32'(BASE_ADDR)) >> WORD_SHIFT) * 32'(BEATS);
      wdata_q     <= writedata;
      be_q        <= byte_en;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      read_data <= '0;
    end else if (in_access && !is_wr_q && last_cyc) begin
      read_data[SRAM_BUS_W*int'(beat) +: SRAM_BUS_W] <= SRAM_DQ;
    end
  end

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    SRAM_CE_N = 1'b1;
    SRAM_WE_N = 1'b1;
    SRAM_OE_N = 1'b1;
    SRAM_UB_N = 1'b1;
    SRAM_LB_N = 1'b1;
    SRAM_ADDR = '0;
    dq_oe     = 1'b0;
    case (state)
      ST_IDLE: begin
        ready = !req;
        if (req) state_nxt = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (tc) state_nxt = ST_DONE;
        SRAM_CE_N = 1'b0;
        SRAM_ADDR = ADDR_W'(half_base_q + 32'(beat));
        if (is_wr_q) begin
          // WE_N released in the last cycle so data/address hold past the rising edge.
          dq_oe     = 1'b1;
          SRAM_WE_N = last_cyc;
          SRAM_UB_N = !be_slice[1];
          SRAM_LB_N = !be_slice[0];
        end else begin
          SRAM_OE_N = 1'b0;
          SRAM_UB_N = 1'b0;
          SRAM_LB_N = 1'b0;
        end
      end
      ST_DONE: begin
        ready     = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: doc/sram_wide_ctrl.md
SRAM_WIDE_CTRL -- requirements
Module: sram_wide_ctrl

Interface
REQ-001 Parameter DATA_W, default 32, host data width in bits; SHALL be a multiple of 16, max 64.
REQ-002 Parameter ADDR_W, default 18, SRAM half-word address width.
REQ-003 Parameter WAIT_CYCLES, default 4, clocks per SRAM beat; SHALL be >= 2.
REQ-004 Parameter BASE_ADDR, default 1024, byte offset subtracted from the host address.
REQ-005 One clock; reset is asynchronous and active-high.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 rst  in  1  asynchronous active-high reset.
REQ-008 wr_en  in  1  write request, held until ready high.
REQ-009 rd_en  in  1  read request, held until ready high.
REQ-010 address  in  32  host byte address.
REQ-011 writedata  in  DATA_W  write data.
REQ-012 byte_en  in  DATA_W/8  write byte mask, bit i = byte i.
REQ-013 read_data  out  DATA_W  registered read result.
REQ-014 ready  out  1  transaction-complete / idle indication.
REQ-015 SRAM_DQ  inout  16  SRAM data bus.
REQ-016 SRAM_ADDR  out  ADDR_W  SRAM half-word address.
REQ-017 SRAM_WE_N, SRAM_UB_N, SRAM_LB_N, SRAM_CE_N, SRAM_OE_N  out  1 each  active-low SRAM strobes.

Function
REQ-018 BEATS = DATA_W/16; word index = (address - BASE_ADDR) >> log2(DATA_W/8); SRAM_ADDR = word index * BEATS + beat, truncated to ADDR_W.
REQ-019 FSM states IDLE, ACCESS, DONE; IDLE->ACCESS when wr_en|rd_en sampled; ACCESS->DONE after BEATS*WAIT_CYCLES clocks; DONE->IDLE unconditionally after 1 clock.
REQ-020 Request type and address SHALL be latched on the IDLE->ACCESS edge; changes during ACCESS are ignored.
REQ-021 wr_en and rd_en both high: write SHALL be performed; read_data unchanged.
REQ-022 ready = (IDLE and not (wr_en|rd_en)) or DONE; ready SHALL first assert BEATS*WAIT_CYCLES+1 clocks after the request cycle (9 for defaults).
REQ-023 A request still asserted in the cycle after DONE SHALL start a new transaction; the host SHALL drop its request on ready.
REQ-024 Beat b transfers bits [16b+15:16b]; cycle counter 0..WAIT_CYCLES-1 within beat, beat counter 0..BEATS-1; both wrap to 0 at the end of the transaction.
REQ-025 SRAM_CE_N low throughout ACCESS, high otherwise.
REQ-026 Write beat: SRAM_DQ driven with the writedata slice for the whole beat; SRAM_WE_N low for cycles 0..WAIT_CYCLES-2, high in the last cycle; SRAM_UB_N/SRAM_LB_N = inverted byte_en[2b+1]/byte_en[2b].
REQ-027 byte_en all-zero write SHALL still take full latency with UB_N=LB_N=1 (no memory change).
REQ-028 Read beat: SRAM_OE_N, SRAM_UB_N, SRAM_LB_N low, SRAM_WE_N high, SRAM_DQ high-Z; slice captured into read_data on the last cycle of the beat.
REQ-029 Outside write beats SRAM_DQ SHALL be high-Z; outside ACCESS all strobes SHALL be high.

Reset
REQ-030 rst SHALL force IDLE, counters 0, read_data 0, SRAM_ADDR 0, all SRAM strobes 1, SRAM_DQ high-Z, asynchronously.
REQ-031 Reset mid-ACCESS SHALL abort the transaction; partial write beats already issued remain in memory; ready follows REQ-022 after release.

Structure
REQ-032 Package sram_pkg SHALL hold the state enum, SRAM_BUS_W = 16, and default values of DATA_W, ADDR_W, WAIT_CYCLES, BASE_ADDR.
REQ-033 One sub-module sram_beat_counter SHALL implement the nested cycle/beat counters with a terminal-count output.

Verification
REQ-034 Bench SHALL pair the block with a 16-bit behavioural SRAM model of 512 half-words with 5 ns read delay.
REQ-035 Write 0xDEADBEEF to 1024, byte_en=0xF, then read 1024 -> SRAM[0]=0xBEEF, SRAM[1]=0xDEAD, read_data=0xDEADBEEF, ready high 9 clocks after each request.
REQ-036 Write 0x11223344 to 1028 with byte_en=0x2 over prior 0 -> SRAM[2]=0x3300, SRAM[3]=0x0000; UB_N=0,LB_N=1 beat 0, both 1 beat 1.
REQ-037 wr_en=rd_en=1, address 1032, writedata 0xA5A5A5A5 -> memory written, read_data unchanged.
REQ-038 rst asserted at ACCESS cycle 5 of a write -> immediate IDLE, strobes high, DQ high-Z, only SRAM beat 0 updated.
REQ-039 DATA_W=64, WAIT_CYCLES=2: write/read 0x0123456789ABCDEF at 1024 -> four beats, ready at clock 9, read_data matches.
